decode_stage_p: RTL

DECODE_STAGE_P -- requirements
Module: decode_stage_p

---
 rtl/decode_stage_p_if.sv | 44 ++++
 rtl/decode_stage_p.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_p_if.sv
// Decode-stage bus: D-stage instruction and write-back port in, E-stage fields and load-use stall out.
interface decode_stage_p_if #(
    parameter int XLEN = 32
);
    logic            validD;
    logic [31:0]     instD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcplus4D;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            flushE;
    logic            stallD;
    logic            validE;
    logic            regwriteE;
    logic            memwriteE;
    logic            jumpE;
    logic            branchE;
    logic            alusrcE;
    logic [1:0]      resultsrcE;
    logic [2:0]      alucontrolE;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] pcplus4E;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] immextE;
    logic [4:0]      rs1E;
    logic [4:0]      rs2E;
    logic [4:0]      rdE;

    modport master (
        output validD, instD, pcD, pcplus4D, we3, a3, wd3, flushE,
        input  stallD, validE, regwriteE, memwriteE, jumpE, branchE, alusrcE,
               resultsrcE, alucontrolE, pcE, pcplus4E, rd1E, rd2E, immextE,
               rs1E, rs2E, rdE
    );

    modport slave (
        input  validD, instD, pcD, pcplus4D, we3, a3, wd3, flushE,
        output stallD, validE, regwriteE, memwriteE, jumpE, branchE, alusrcE,
               resultsrcE, alucontrolE, pcE, pcplus4E, rd1E, rd2E, immextE,
               rs1E, rs2E, rdE
    );
endinterface

// File: rtl/decode_stage_p.sv
// RV32/64 decode stage: register file with write-through, main/ALU decode, load-use stall, ID/EX register.
// Optional JAL/JALR decode enabled by defining DECODE_STAGE_P_JUMP_EN.
module decode_stage_p #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    decode_stage_p_if.slave bus
);
    localparam int         RW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_W   = 6'(NREG);
    localparam logic [4:0] IDX_MASK = 5'((1 << RW) - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef DECODE_STAGE_P_JUMP_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_e;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic            jump;
        logic            branch;
        logic            alusrc;
        logic [1:0]      resultsrc;
        logic [2:0]      alucontrol;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_t;

    ex_t                       ex_q, ex_d;
    logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_d, rs2_d, rd_d;

    assign inst   = bus.instD;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1_d  = inst[19:15];
    assign rs2_d  = inst[24:20];
    assign rd_d   = inst[11:7];

    // Register file: out-of-range and x0 writes are dropped, reset wins over write-back.
    logic wr_en;
    assign wr_en = bus.we3 && (bus.a3 != 5'd0) && ({1'b0, bus.a3} < NREG_W);

    always_comb begin
        rf_d = rf_q;
        if (rst) begin
            rf_d = '0;
        end else if (wr_en) begin
            rf_d[bus.a3[RW-1:0]] = bus.wd3;
        end
    end

    logic [1:0][4:0]      ra;
    logic [1:0][XLEN-1:0] rdata;

    always_comb begin
        ra[0] = rs1_d;
        ra[1] = rs2_d;
        rdata = '0;
        for (int p = 0; p < 2; p++) begin
            if ((ra[p] != 5'd0) && ({1'b0, ra[p]} < NREG_W)) begin
                if (wr_en && (bus.a3 == ra[p])) begin
                    rdata[p] = bus.wd3;
                end else begin
                    rdata[p] = rf_q[ra[p][RW-1:0]];
                end
            end
        end
    end

    // Main decoder
    logic       regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
    logic       legal_d, uses_rs2_d;
    logic [1:0] resultsrc_d, aluop_d;
    imm_sel_e   immsrc_d;

    always_comb begin
        regwrite_d  = 1'b0;
        memwrite_d  = 1'b0;
        jump_d      = 1'b0;
        branch_d    = 1'b0;
        alusrc_d    = 1'b0;
        resultsrc_d = 2'b00;
        aluop_d     = 2'b00;
        immsrc_d    = IMM_NONE;
        legal_d     = 1'b0;
        uses_rs2_d  = 1'b0;
        case (opcode)
            OP_R: begin
                legal_d    = 1'b1;
                regwrite_d = 1'b1;
                aluop_d    = 2'b10;
                uses_rs2_d = 1'b1;
            end
            OP_I: begin
                legal_d    = 1'b1;
                regwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                immsrc_d   = IMM_I;
                aluop_d    = 2'b10;
            end
            OP_LOAD: begin
                legal_d     = 1'b1;
                regwrite_d  = 1'b1;
                resultsrc_d = 2'b01;
                alusrc_d    = 1'b1;
                immsrc_d    = IMM_I;
            end
            OP_STORE: begin
                legal_d    = 1'b1;
                memwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                immsrc_d   = IMM_S;
                uses_rs2_d = 1'b1;
            end
            OP_BRANCH: begin
                legal_d    = 1'b1;
                branch_d   = 1'b1;
                immsrc_d   = IMM_B;
                aluop_d    = 2'b01;
                uses_rs2_d = 1'b1;
            end
`ifdef DECODE_STAGE_P_JUMP_EN
            OP_JAL: begin
                legal_d     = 1'b1;
                regwrite_d  = 1'b1;
                jump_d      = 1'b1;
                resultsrc_d = 2'b10;
                immsrc_d    = IMM_J;
            end
            OP_JALR: begin
                legal_d     = 1'b1;
                regwrite_d  = 1'b1;
                jump_d      = 1'b1;
                resultsrc_d = 2'b10;
                alusrc_d    = 1'b1;
                immsrc_d    = IMM_I;
            end
`endif
            default: ;
        endcase
    end

    // ALU decoder; only R-type (op[5]=1) turns funct3=000 into sub.
    logic [2:0] alucontrol_d;

    always_comb begin
        alucontrol_d = 3'b000;
        case (aluop_d)
            2'b01: alucontrol_d = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol_d = (opcode[5] && inst[30]) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol_d = 3'b101;
                    3'b110:  alucontrol_d = 3'b011;
                    3'b111:  alucontrol_d = 3'b010;
                    default: alucontrol_d = 3'b000;
                endcase
            end
            default: alucontrol_d = 3'b000;
        endcase
    end

    logic [XLEN-1:0] immext_d;

    always_comb begin
        immext_d = '0;
        case (immsrc_d)
            IMM_I: immext_d = {{(XLEN-12){inst[31]}}, inst[31:20]};
            IMM_S: immext_d = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: immext_d = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                               inst[11:8], 1'b0};
`ifdef DECODE_STAGE_P_JUMP_EN
            IMM_J: immext_d = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                               inst[30:21], 1'b0};
`endif
            default: immext_d = '0;
        endcase
    end

    // Load-use: rs2 only counts for formats that actually read it.
    logic stall;
    assign stall = bus.validD && ex_q.valid && (ex_q.resultsrc == 2'b01) &&
                   (ex_q.rd != 5'd0) &&
                   ((ex_q.rd == rs1_d) || ((ex_q.rd == rs2_d) && uses_rs2_d));

    always_comb begin
        ex_d = '0;
        if (!rst && !bus.flushE && !stall && bus.validD && legal_d) begin
            ex_d.valid      = 1'b1;
            ex_d.regwrite   = regwrite_d;
            ex_d.memwrite   = memwrite_d;
            ex_d.jump       = jump_d;
            ex_d.branch     = branch_d;
            ex_d.alusrc     = alusrc_d;
            ex_d.resultsrc  = resultsrc_d;
            ex_d.alucontrol = alucontrol_d;
            ex_d.pc         = bus.pcD;
            ex_d.pcplus4    = bus.pcplus4D;
            ex_d.rd1        = rdata[0];
            ex_d.rd2        = rdata[1];
            ex_d.immext     = immext_d;
            ex_d.rs1        = rs1_d & IDX_MASK;
            ex_d.rs2        = rs2_d & IDX_MASK;
            ex_d.rd         = rd_d & IDX_MASK;
        end
    end

    always_ff @(posedge clk) begin
        ex_q <= ex_d;
        rf_q <= rf_d;
    end

    assign bus.stallD      = stall;
    assign bus.validE      = ex_q.valid;
    assign bus.regwriteE   = ex_q.regwrite;
    assign bus.memwriteE   = ex_q.memwrite;
    assign bus.jumpE       = ex_q.jump;
    assign bus.branchE     = ex_q.branch;
    assign bus.alusrcE     = ex_q.alusrc;
    assign bus.resultsrcE  = ex_q.resultsrc;
    assign bus.alucontrolE = ex_q.alucontrol;
    assign bus.pcE         = ex_q.pc;
    assign bus.pcplus4E    = ex_q.pcplus4;
    assign bus.rd1E        = ex_q.rd1;
    assign bus.rd2E        = ex_q.rd2;
    assign bus.immextE     = ex_q.immext;
    assign bus.rs1E        = ex_q.rs1;
    assign bus.rs2E        = ex_q.rs2;
    assign bus.rdE         = ex_q.rd;
endmodule
